alu_issue_stage: RTL

//  Producer side of the RV32 ALU control interface. Decodes RV32I instructions into the 4-bit ALU

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_op_decode.sv | 92 +++++++++
 rtl/alu_issue_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the RV32 ALU control interface: ALU
//               control codes, RV32I opcode values, skid-buffer state
//               encoding and the decoded-op record carried through the
//               issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int XLEN_SUPPORTED = 32;

   // ALU control codes
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_NOR  = 4'd12;  // reserved for a future custom-0 opcode

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   // One decoded ALU operation
   typedef struct packed {
      logic [3:0]  control;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        illegal;
   } alu_op_t;

   function automatic logic [31:0] sext12(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Pure combinational RV32I decode into an ALU op record.
// Ports       : instr_i  - instruction word
//               rs1_i    - rs1 read data
//               rs2_i    - rs2 read data
//               op_o     - control / a / b / rd / illegal
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
   import alu_pkg::*;
#(
   parameter bit MEM_ADDR_EN = 1'b1,
   parameter bit BRANCH_EN   = 1'b1
) (
   input  logic [31:0] instr_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   output alu_op_t     op_o
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_f3;
   logic        w_f7b5;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [3:0]  w_ctl;
   logic [31:0] w_b;
   logic        w_legal;
   logic        w_writes_rd;
   logic        unused_rs_fields;

   assign w_opcode = instr_i[6:0];
   assign w_f3     = instr_i[14:12];
   assign w_f7b5   = instr_i[30];
   assign w_imm_i  = sext12(instr_i[31:20]);
   assign w_imm_s  = sext12({instr_i[31:25], instr_i[11:7]});

   // Register specifiers are resolved upstream; only their data arrives here.
   assign unused_rs_fields = ^instr_i[19:15];

   always_comb begin
      w_ctl       = ALU_ADD;
      w_b         = rs2_i;
      w_legal     = 1'b0;
      w_writes_rd = 1'b1;
      case (w_opcode)
         OPC_OP, OPC_OPIMM: begin
            w_legal = 1'b1;
            w_b     = (w_opcode == OPC_OP) ? rs2_i : w_imm_i;
            case (w_f3)
               3'b000:  w_ctl = (w_opcode == OPC_OP && w_f7b5) ? ALU_SUB : ALU_ADD;
               3'b111:  w_ctl = ALU_AND;
               3'b110:  w_ctl = ALU_OR;
               3'b011:  w_ctl = ALU_SLTU;
               default: w_legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            w_legal = MEM_ADDR_EN;
            w_b     = w_imm_i;
         end
         OPC_STORE: begin
            w_legal     = MEM_ADDR_EN;
            w_b         = w_imm_s;
            w_writes_rd = 1'b0;
         end
         OPC_BRANCH: begin
            // Only BEQ/BNE: the consumer tests the SUB result for zero.
            w_legal     = BRANCH_EN && (w_f3 == 3'b000 || w_f3 == 3'b001);
            w_ctl       = ALU_SUB;
            w_writes_rd = 1'b0;
         end
         default: w_legal = 1'b0;
      endcase
   end

   // Illegal ops are still issued, but carry an all-zero payload.
   always_comb begin
      op_o         = '0;
      op_o.illegal = !w_legal;
      if (w_legal) begin
         op_o.control = w_ctl;
         op_o.a       = rs1_i;
         op_o.b       = w_b;
         op_o.rd      = w_writes_rd ? instr_i[11:7] : 5'd0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Decodes RV32I instructions and issues ALU ops through a
//               registered valid/ready stage backed by a 2-entry skid buffer.
// Ports       : clk, reset_n (async, active low), flush (sync drop)
//               in_valid/in_ready/in_instr/in_rs1/in_rs2  - upstream
//               out_valid/out_ready/out_control/out_a/out_b/out_rd/
//               out_illegal                               - ALU side
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter bit MEM_ADDR_EN = 1'b1,
   parameter bit BRANCH_EN   = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_control,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   skid_state_t state_q, state_d;
   alu_op_t     head_q, head_d;   // oldest op, drives out_*
   alu_op_t     tail_q, tail_d;   // second op, held only while FULL
   alu_op_t     w_dec;
   logic        w_push;
   logic        w_pop;

   alu_op_decode #(
      .MEM_ADDR_EN (MEM_ADDR_EN),
      .BRANCH_EN   (BRANCH_EN)
   ) u_decode (
      .instr_i (in_instr),
      .rs1_i   (in_rs1),
      .rs2_i   (in_rs2),
      .op_o    (w_dec)
   );

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         // Data registers keep their contents; only occupancy is cleared.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (w_push) begin
                  head_d  = w_dec;
                  state_d = ONE;
               end
            end
            ONE: begin
               case ({w_push, w_pop})
                  2'b11: head_d = w_dec;
                  2'b10: begin
                     tail_d  = w_dec;
                     state_d = FULL;
                  end
                  2'b01: state_d = EMPTY;
                  default: state_d = ONE;
               endcase
            end
            FULL: begin
               // in_ready is low here, so a pop never coincides with a push.
               if (w_pop) begin
                  head_d  = tail_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign out_control = head_q.control;
   assign out_a       = head_q.a;
   assign out_b       = head_q.b;
   assign out_rd      = head_q.rd;
   assign out_illegal = head_q.illegal;

endmodule
`default_nettype wire
